wb_region_router: RTL and testbench

//  N-region Wishbone B4 pipelined address router for the data port of the RV32I core.

---
 rtl/wb_region_router_pkg.sv | 16 +
 rtl/wb_region_router_if.sv | 46 ++++
 rtl/wb_region_router_match.sv | 19 +
 rtl/wb_region_router.sv | 161 ++++++++++++++++
 tb/tb_wb_region_router.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_region_router_pkg.sv
// Shared types for the Wishbone region router.
// Provides the target id type, error id helper and error data word.
package wb_router_pkg;

   // Wide enough for NUM_REGIONS up to 16 plus the error target.
   localparam int TGT_W = 5;

   typedef logic [TGT_W-1:0] tgt_id_t;

   localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

   function automatic tgt_id_t err_id(input int n);
      return tgt_id_t'(n);
   endfunction

endpackage

// File: rtl/wb_region_router_if.sv
// Wishbone B4 pipelined bundle: core side (m_*) and per-slave side (s_*).
// Modport slave is the router view; modport master is the core/memory view.
interface wb_region_router_if #(
   parameter int NUM_REGIONS = 4,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32
);
   localparam int SEL_W = DATA_W / 8;

   logic                          m_cyc_i;
   logic                          m_stb_i;
   logic                          m_we_i;
   logic [ADDR_W-1:0]             m_adr_i;
   logic [DATA_W-1:0]             m_dat_i;
   logic [SEL_W-1:0]              m_sel_i;
   logic                          m_stall_o;
   logic                          m_ack_o;
   logic                          m_err_o;
   logic [DATA_W-1:0]             m_dat_o;

   logic [NUM_REGIONS-1:0]        s_cyc_o;
   logic [NUM_REGIONS-1:0]        s_stb_o;
   logic [NUM_REGIONS*ADDR_W-1:0] s_adr_o;
   logic                          s_we_o;
   logic [DATA_W-1:0]             s_dat_o;
   logic [SEL_W-1:0]              s_sel_o;
   logic [NUM_REGIONS-1:0]        s_stall_i;
   logic [NUM_REGIONS-1:0]        s_ack_i;
   logic [NUM_REGIONS-1:0]        s_err_i;
   logic [NUM_REGIONS*DATA_W-1:0] s_dat_i;

   modport slave (
      input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
      output m_stall_o, m_ack_o, m_err_o, m_dat_o,
      output s_cyc_o, s_stb_o, s_adr_o, s_we_o, s_dat_o, s_sel_o,
      input  s_stall_i, s_ack_i, s_err_i, s_dat_i
   );

   modport master (
      output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
      input  m_stall_o, m_ack_o, m_err_o, m_dat_o,
      input  s_cyc_o, s_stb_o, s_adr_o, s_we_o, s_dat_o, s_sel_o,
      output s_stall_i, s_ack_i, s_err_i, s_dat_i
   );

endinterface

// File: rtl/wb_region_router_match.sv
// One base/size address comparator.
// Ports: base_i, size_i, adr_i in; hit_o and region-local loc_adr_o out.
module wb_region_match #(
   parameter int ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] base_i,
   input  logic [ADDR_W-1:0] size_i,
   input  logic [ADDR_W-1:0] adr_i,
   output logic              hit_o,
   output logic [ADDR_W-1:0] loc_adr_o
);

   assign loc_adr_o = adr_i - base_i;

   // Offset compare avoids overflow of base+size at the top of memory.
   assign hit_o = (size_i != '0) && (adr_i >= base_i)
                  && (loc_adr_o < size_i);

endmodule

// File: rtl/wb_region_router.sv
// N-region Wishbone B4 pipelined router with in-order response tracking.
// Ports: clk, rst, region_base_i/size_i, bus (slave modport), timeout_o; watchdog under WB_RTR_TIMEOUT_EN.
module wb_region_router
   import wb_router_pkg::*;
#(
   parameter int NUM_REGIONS     = 4,
   parameter int ADDR_W          = 32,
   parameter int DATA_W          = 32,
   parameter int MAX_OUTSTANDING = 4,
   parameter int TIMEOUT_CYCLES  = 256
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REGIONS*ADDR_W-1:0] region_base_i,
   input  logic [NUM_REGIONS*ADDR_W-1:0] region_size_i,
   wb_region_router_if.slave             bus,
   output logic                          timeout_o
);

   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
   localparam tgt_id_t ERR_ID = err_id(NUM_REGIONS);

   logic [NUM_REGIONS-1:0] hit;
   logic [CNT_W-1:0]       cnt;
   logic [CNT_W-1:0]       cnt_nxt;
   tgt_id_t                cur_tgt;
   tgt_id_t                target;
   logic                   err_pend;
   logic                   slv_stall;
   logic                   slv_ack;
   logic                   slv_err;
   logic [DATA_W-1:0]      slv_dat;
   logic                   busy;
   logic                   rtr_stall;
   logic                   stall;
   logic                   accept;
   logic                   live;
   logic                   err_rsp;
   logic                   ack_rsp;
   logic                   serr_rsp;
   logic                   rsp;
   logic                   wdog_fire;

   for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_match
      wb_region_match #(.ADDR_W(ADDR_W)) u_match (
         .base_i    (region_base_i[g*ADDR_W +: ADDR_W]),
         .size_i    (region_size_i[g*ADDR_W +: ADDR_W]),
         .adr_i     (bus.m_adr_i),
         .hit_o     (hit[g]),
         .loc_adr_o (bus.s_adr_o[g*ADDR_W +: ADDR_W])
      );
   end

   // Lowest index wins on overlapping regions.
   always_comb begin
      target = ERR_ID;
      for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
         if (hit[i]) target = tgt_id_t'(i);
      end
   end

   always_comb begin
      slv_stall = 1'b0;
      slv_ack   = 1'b0;
      slv_err   = 1'b0;
      slv_dat   = '0;
      for (int i = 0; i < NUM_REGIONS; i++) begin
         if (target == tgt_id_t'(i)) slv_stall = bus.s_stall_i[i];
         if (cur_tgt == tgt_id_t'(i)) begin
            slv_ack = bus.s_ack_i[i];
            slv_err = bus.s_err_i[i];
            slv_dat = bus.s_dat_i[i*DATA_W +: DATA_W];
         end
      end
   end

   assign busy      = (cnt != '0);
   // Router-side stall: full, or a region switch waiting for drain.
   assign rtr_stall = (cnt == CNT_MAX) | (busy & (target != cur_tgt));
   assign stall     = !rst & (rtr_stall | slv_stall);
   assign accept    = bus.m_cyc_i & bus.m_stb_i & !stall;

   assign live     = bus.m_cyc_i & busy;
   assign err_rsp  = live & err_pend;
   assign ack_rsp  = live & !err_pend & slv_ack;
   assign serr_rsp = live & !err_pend & slv_err;
   assign rsp      = err_rsp | ack_rsp | serr_rsp;
   assign cnt_nxt  = cnt + CNT_W'(accept) - CNT_W'(rsp);

   assign bus.m_stall_o = stall;
   assign bus.m_ack_o   = ack_rsp;
   assign bus.m_err_o   = err_rsp | serr_rsp | wdog_fire;

   always_comb begin
      bus.m_dat_o = '0;
      if (err_rsp | wdog_fire) bus.m_dat_o = DATA_W'(ERR_DATA);
      else if (live & !err_pend) bus.m_dat_o = slv_dat;
   end

   always_comb begin
      bus.s_cyc_o = '0;
      bus.s_stb_o = '0;
      for (int i = 0; i < NUM_REGIONS; i++) begin
         bus.s_cyc_o[i] = !rst & bus.m_cyc_i
            & ((target == tgt_id_t'(i))
               | (busy & (cur_tgt == tgt_id_t'(i))));
         bus.s_stb_o[i] = !rst & bus.m_cyc_i & bus.m_stb_i
            & (target == tgt_id_t'(i)) & !rtr_stall;
      end
   end

   assign bus.s_we_o  = bus.m_we_i;
   assign bus.s_dat_o = bus.m_dat_i;
   assign bus.s_sel_o = bus.m_sel_i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         cur_tgt  <= '0;
         err_pend <= 1'b0;
      end else if (!bus.m_cyc_i || wdog_fire) begin
         cnt      <= '0;
         err_pend <= 1'b0;
      end else begin
         cnt <= cnt_nxt;
         if (accept) begin
            cur_tgt  <= target;
            err_pend <= (target == ERR_ID);
         end else begin
            err_pend <= err_pend & (cnt_nxt != '0);
         end
      end
   end

`ifdef WB_RTR_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WD_W-1:0] wdog;
   logic            to_q;

   assign wdog_fire = live & !rsp
                      & (wdog == WD_W'(TIMEOUT_CYCLES - 1));
   assign timeout_o = to_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wdog <= '0;
         to_q <= 1'b0;
      end else begin
         if (!live || rsp || wdog_fire) wdog <= '0;
         else wdog <= wdog + 1'b1;
         if (wdog_fire) to_q <= 1'b1;
      end
   end
`else
   assign wdog_fire = 1'b0;
   assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_region_router.sv
// Directed self-checking bench for wb_region_router.
// Drives the interface master side by hand and checks with immediate assertions.
module tb_wb_region_router;

   localparam int NR = 4;
   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic [NR*AW-1:0] base;
   logic [NR*AW-1:0] size;
   logic          timeout;
   int            tests = 0;
   int            fails = 0;
   int            n;

   always #5 clk = ~clk;

   wb_region_router_if #(.NUM_REGIONS(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

   wb_region_router #(
      .NUM_REGIONS(NR), .ADDR_W(AW), .DATA_W(DW),
      .MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(16)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .region_base_i (base),
      .region_size_i (size),
      .bus           (bus),
      .timeout_o     (timeout)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      bus.m_cyc_i   = 1'b1;
      bus.m_stb_i   = 1'b1;
      bus.m_we_i    = 1'b0;
      bus.m_adr_i   = 32'h8000_1004;
      bus.m_dat_i   = 32'h0;
      bus.m_sel_i   = 4'hF;
      bus.s_stall_i = '0;
      bus.s_ack_i   = '0;
      bus.s_err_i   = '0;
      bus.s_dat_i   = '0;
      base = {32'h0, 32'h0, 32'h8000_1000, 32'h8000_0000};
      size = {32'h0, 32'h0, 32'h0001_0000, 32'h0000_1000};
      rst  = 1'b1;

      tick();
      tick();
      chk("rst_stall", bus.m_stall_o, 0);
      chk("rst_stb", bus.s_stb_o, 0);
      chk("rst_cyc", bus.s_cyc_o, 0);
      chk("rst_ack", bus.m_ack_o, 0);
      chk("rst_err", bus.m_err_o, 0);
      chk("rst_dat", bus.m_dat_o, 0);
      chk("rst_to", timeout, 0);
      bus.m_cyc_i = 1'b0;
      bus.m_stb_i = 1'b0;
      rst = 1'b0;
      tick();

      // Single read to region 1.
      bus.m_cyc_i = 1'b1;
      bus.m_stb_i = 1'b1;
      settle();
      chk("t1_stb", bus.s_stb_o, 4'b0010);
      chk("t1_adr", bus.s_adr_o[63:32], 32'h4);
      chk("t1_cyc", bus.s_cyc_o, 4'b0010);
      chk("t1_stall", bus.m_stall_o, 0);
      tick();
      bus.m_stb_i = 1'b0;
      bus.s_ack_i = 4'b0010;
      bus.s_dat_i[63:32] = 32'h1234_5678;
      settle();
      chk("t1_ack", bus.m_ack_o, 1);
      chk("t1_dat", bus.m_dat_o, 32'h1234_5678);
      chk("t1_err", bus.m_err_o, 0);
      tick();
      bus.s_ack_i = '0;
      settle();
      chk("t1_idle", bus.m_ack_o, 0);

      // Four back-to-back reads fill the tracker, fifth stalls.
      bus.m_adr_i = 32'h8000_0010;
      bus.m_stb_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         settle();
         chk("t2_go", bus.m_stall_o, 0);
         tick();
      end
      settle();
      chk("t2_full", bus.m_stall_o, 1);
      chk("t2_nostb", bus.s_stb_o, 0);
      tick();
      chk("t2_full2", bus.m_stall_o, 1);
      bus.s_ack_i = 4'b0001;
      bus.s_dat_i[31:0] = 32'hA0;
      settle();
      chk("t2_ack0", bus.m_ack_o, 1);
      chk("t2_dat0", bus.m_dat_o, 32'hA0);
      chk("t2_stl0", bus.m_stall_o, 1);
      tick();
      bus.s_dat_i[31:0] = 32'hA1;
      settle();
      chk("t2_go5", bus.m_stall_o, 0);
      chk("t2_ack1", bus.m_ack_o, 1);
      chk("t2_dat1", bus.m_dat_o, 32'hA1);
      tick();
      bus.m_stb_i = 1'b0;
      for (int j = 2; j <= 4; j++) begin
         bus.s_dat_i[31:0] = 32'hA0 + j;
         settle();
         chk("t2_ackn", bus.m_ack_o, 1);
         chk("t2_datn", bus.m_dat_o, 32'hA0 + j);
         tick();
      end
      settle();
      chk("t2_ign", bus.m_ack_o, 0);
      bus.s_ack_i = '0;

      // Region switch waits for drain.
      bus.m_adr_i = 32'h8000_0020;
      bus.m_stb_i = 1'b1;
      settle();
      tick();
      bus.m_adr_i = 32'h8000_1008;
      settle();
      chk("t3_stall", bus.m_stall_o, 1);
      chk("t3_nostb", bus.s_stb_o, 0);
      chk("t3_cyc", bus.s_cyc_o, 4'b0011);
      tick();
      bus.s_ack_i = 4'b0001;
      bus.s_dat_i[31:0] = 32'hA5;
      settle();
      chk("t3_ack0", bus.m_ack_o, 1);
      chk("t3_dat0", bus.m_dat_o, 32'hA5);
      chk("t3_stl0", bus.m_stall_o, 1);
      tick();
      bus.s_ack_i = '0;
      settle();
      chk("t3_go", bus.m_stall_o, 0);
      chk("t3_stb1", bus.s_stb_o, 4'b0010);
      tick();
      bus.m_stb_i = 1'b0;
      bus.s_ack_i = 4'b0001;
      settle();
      chk("t3_wrong", bus.m_ack_o, 0);
      tick();
      bus.s_ack_i = 4'b0010;
      bus.s_dat_i[63:32] = 32'hB1;
      settle();
      chk("t3_ack1", bus.m_ack_o, 1);
      chk("t3_dat1", bus.m_dat_o, 32'hB1);
      tick();
      bus.s_ack_i = '0;

      // Unmapped access.
      bus.m_adr_i = 32'h9000_0000;
      bus.m_stb_i = 1'b1;
      settle();
      chk("t4_nostb", bus.s_stb_o, 0);
      chk("t4_stall", bus.m_stall_o, 0);
      chk("t4_nocyc", bus.s_cyc_o, 0);
      tick();
      bus.m_stb_i = 1'b0;
      settle();
      chk("t4_err", bus.m_err_o, 1);
      chk("t4_dat", bus.m_dat_o, 32'hDEAD_BEEF);
      chk("t4_ack", bus.m_ack_o, 0);
      tick();
      chk("t4_done", bus.m_err_o, 0);

      // Abort with two outstanding.
      bus.m_adr_i = 32'h8000_0030;
      bus.m_stb_i = 1'b1;
      settle();
      tick();
      settle();
      tick();
      bus.m_stb_i = 1'b0;
      bus.m_cyc_i = 1'b0;
      settle();
      chk("t5_cyc0", bus.s_cyc_o, 0);
      tick();
      bus.m_cyc_i = 1'b1;
      bus.s_ack_i = 4'b0001;
      settle();
      chk("t5_late", bus.m_ack_o, 0);
      tick();
      bus.s_ack_i = '0;

      // Reset mid-burst.
      bus.m_stb_i = 1'b1;
      settle();
      tick();
      tick();
      rst = 1'b1;
      bus.s_ack_i = 4'b0001;
      settle();
      chk("t5_rstall", bus.m_stall_o, 0);
      chk("t5_rstb", bus.s_stb_o, 0);
      chk("t5_rcyc", bus.s_cyc_o, 0);
      chk("t5_rack", bus.m_ack_o, 0);
      chk("t5_rdat", bus.m_dat_o, 0);
      tick();
      rst = 1'b0;
      bus.m_stb_i = 1'b0;
      settle();
      chk("t5_disc", bus.m_ack_o, 0);
      bus.s_ack_i = '0;
      tick();

`ifdef WB_RTR_TIMEOUT_EN
      // Stuck slave trips the watchdog.
      bus.m_adr_i = 32'h8000_0040;
      bus.m_stb_i = 1'b1;
      settle();
      tick();
      bus.m_stb_i = 1'b0;
      n = 0;
      for (int k = 1; k <= 40 && n == 0; k++) begin
         settle();
         if (bus.m_err_o) n = k;
         else tick();
      end
      chk("t6_cycles", n, 16);
      chk("t6_dat", bus.m_dat_o, 32'hDEAD_BEEF);
      tick();
      settle();
      chk("t6_once", bus.m_err_o, 0);
      chk("t6_sticky", timeout, 1);
`else
      chk("t6_to_off", timeout, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
